serial_host_link: RTL and testbench

SERIAL_HOST_LINK -- requirements
Module: serial_host_link

---
 rtl/serial_host_link.sv | 175 +++++++++++++++++
 tb/tb_serial_host_link.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_host_link.sv
// serial_host_link: parallel-to-serial TX and serial-to-parallel RX link, both LSB first.
//
// TX path: a word handed over on i_tx_word/i_tx_valid/o_tx_ready is shifted out on
// o_sdout/o_sdout_valid, one bit per transfer (o_sdout_valid && i_sready). After the
// last bit the line stays idle for a gap before the next word can be accepted.
// RX path: bits on i_sdin/i_sdin_valid are collected while o_sready is high. A complete
// word appears on o_rx_word with a one-cycle o_rx_valid pulse. If the word is cut short,
// the partial bits are dropped and o_rx_err pulses for one cycle.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_en                              enable for new TX words and for RX
//   i_tx_word, i_tx_valid, o_tx_ready parallel TX handshake
//   o_sdout, o_sdout_valid, i_sready  serial TX
//   i_sdin, i_sdin_valid, o_sready    serial RX
//   o_rx_word, o_rx_valid, o_rx_err   parallel RX result
//
// Configuration: with the macro SERIAL_HOST_LINK_GAP_EN defined, the post-word gap lasts
// GAP_CYCLES cycles. Without it, the gap lasts one cycle and no gap counter is built.
module serial_host_link #(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned GAP_CYCLES = 50
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic [DATA_WIDTH-1:0] i_tx_word,
   input  logic                  i_tx_valid,
   output logic                  o_tx_ready,
   output logic                  o_sdout,
   output logic                  o_sdout_valid,
   input  logic                  i_sready,
   input  logic                  i_sdin,
   input  logic                  i_sdin_valid,
   output logic                  o_sready,
   output logic [DATA_WIDTH-1:0] o_rx_word,
   output logic                  o_rx_valid,
   output logic                  o_rx_err
);

   localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StGap} tx_state_e;

   // ---------------------------------------------------------------- TX path
   tx_state_e             tx_state_q;
   logic [DATA_WIDTH-1:0] tx_shift_q;
   logic [CntW-1:0]       tx_cnt_q;
   logic                  sdout_q;
   logic                  sdout_valid_q;
   logic                  tx_accept;
   logic                  tx_xfer;
   logic                  gap_done;

   assign o_tx_ready    = (tx_state_q == StIdle) && i_en && !i_rst;
   assign tx_accept     = o_tx_ready && i_tx_valid;
   assign tx_xfer       = sdout_valid_q && i_sready;
   assign o_sdout       = sdout_q;
   assign o_sdout_valid = sdout_valid_q;

`ifdef SERIAL_HOST_LINK_GAP_EN
   localparam int unsigned GapW = 10;
   logic [GapW-1:0] gap_cnt_q;

   // Counts cycles spent in StGap; restarts from zero on every entry.
   always_ff @(posedge i_clk) begin
      if (i_rst || (tx_state_q != StGap)) begin
         gap_cnt_q <= '0;
      end else if (!gap_done) begin
         gap_cnt_q <= gap_cnt_q + GapW'(1);
      end
   end

   assign gap_done = (gap_cnt_q == GapW'(GAP_CYCLES - 1));
`else
   logic unused_gap_cycles;
   assign unused_gap_cycles = (GAP_CYCLES != 0);
   assign gap_done          = 1'b1;
`endif

   // TX FSM. sdout/sdout_valid are registered and are updated together with the state,
   // so they always present the bit the shift register will hand over next.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_state_q    <= StIdle;
         tx_shift_q    <= '0;
         tx_cnt_q      <= '0;
         sdout_q       <= 1'b0;
         sdout_valid_q <= 1'b0;
      end else begin
         unique case (tx_state_q)
            StIdle: begin
               if (tx_accept) begin
                  tx_shift_q    <= i_tx_word;
                  tx_cnt_q      <= '0;
                  sdout_q       <= i_tx_word[0];
                  sdout_valid_q <= 1'b1;
                  tx_state_q    <= StShift;
               end
            end
            StShift: begin
               if (tx_xfer) begin
                  tx_shift_q <= tx_shift_q >> 1;
                  if (tx_cnt_q == LastBit) begin
                     tx_cnt_q      <= '0;
                     sdout_q       <= 1'b0;
                     sdout_valid_q <= 1'b0;
                     tx_state_q    <= StGap;
                  end else begin
                     tx_cnt_q <= tx_cnt_q + CntW'(1);
                     sdout_q  <= tx_shift_q[1];
                  end
               end
            end
            StGap: begin
               if (gap_done) begin
                  tx_state_q <= StIdle;
               end
            end
            default: begin
               tx_state_q    <= StIdle;
               sdout_q       <= 1'b0;
               sdout_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- RX path
   logic [DATA_WIDTH-1:0] rx_shift_q;
   logic [DATA_WIDTH-1:0] rx_next;
   logic [DATA_WIDTH-1:0] rx_word_q;
   logic [CntW-1:0]       rx_cnt_q;
   logic                  rx_valid_q;
   logic                  rx_err_q;
   logic                  rx_xfer;

   assign o_sready   = i_en && !i_rst;
   assign rx_xfer    = i_sdin_valid && o_sready;
   // New bit enters at the MSB so that after DATA_WIDTH bits the first one sits at bit 0.
   assign rx_next    = {i_sdin, rx_shift_q[DATA_WIDTH-1:1]};
   assign o_rx_word  = rx_word_q;
   assign o_rx_valid = rx_valid_q;
   assign o_rx_err   = rx_err_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_shift_q <= '0;
         rx_word_q  <= '0;
         rx_cnt_q   <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         if (rx_xfer) begin
            rx_shift_q <= rx_next;
            if (rx_cnt_q == LastBit) begin
               rx_word_q  <= rx_next;
               rx_valid_q <= 1'b1;
               rx_cnt_q   <= '0;
            end else begin
               rx_cnt_q <= rx_cnt_q + CntW'(1);
            end
         end else if (!i_sdin_valid && (rx_cnt_q != '0)) begin
            // Far end dropped valid mid-word: discard the partial word.
            rx_shift_q <= '0;
            rx_cnt_q   <= '0;
            rx_err_q   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_host_link.sv
// Directed testbench for serial_host_link (DATA_WIDTH 24, GAP_CYCLES 50).
module tb_serial_host_link;

`ifdef SERIAL_HOST_LINK_GAP_EN
   localparam int GapExp = 50;
`else
   localparam int GapExp = 1;
`endif

   logic        clk;
   logic        rst;
   logic        en;
   logic [23:0] tx_word;
   logic        tx_valid;
   logic        tx_ready;
   logic        sdout;
   logic        sdout_valid;
   logic        sready_drv;
   logic        sdin_drv;
   logic        sdin_valid_drv;
   logic        dut_sready;
   logic        dut_sdin;
   logic        dut_sdin_valid;
   logic        sready;
   logic [23:0] rx_word;
   logic        rx_valid;
   logic        rx_err;
   logic        lb;

   int n_checks = 0;
   int n_errors = 0;
   int lb_err   = 0;

   assign dut_sdin       = lb ? sdout       : sdin_drv;
   assign dut_sdin_valid = lb ? sdout_valid : sdin_valid_drv;
   assign dut_sready     = lb ? sready      : sready_drv;

   serial_host_link #(
      .DATA_WIDTH(24),
      .GAP_CYCLES(50)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_en          (en),
      .i_tx_word     (tx_word),
      .i_tx_valid    (tx_valid),
      .o_tx_ready    (tx_ready),
      .o_sdout       (sdout),
      .o_sdout_valid (sdout_valid),
      .i_sready      (dut_sready),
      .i_sdin        (dut_sdin),
      .i_sdin_valid  (dut_sdin_valid),
      .o_sready      (sready),
      .o_rx_word     (rx_word),
      .o_rx_valid    (rx_valid),
      .o_rx_err      (rx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (lb && rx_err) lb_err <= lb_err + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Sends one word and watches the serial side until o_tx_ready returns.
   task automatic send_tx(input logic [23:0] w, input bit toggle, input bit drop_en,
                          output logic [23:0] got, output int vcyc, output int nx,
                          output int gap, output bit ok);
      int k;
      got  = '0;
      vcyc = 0;
      nx   = 0;
      gap  = 0;
      ok   = 1'b0;
      k    = 0;
      while (!tx_ready && k < 200) begin
         tick();
         k++;
      end
      if (!tx_ready) return;
      tx_valid = 1'b1;
      tx_word  = w;
      tick();
      tx_valid = 1'b0;
      if (drop_en) en = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (toggle) sready_drv = c[0];
         #1;
         if (sdout_valid) begin
            vcyc++;
            if (sready_drv) begin
               if (nx < 24) got[nx] = sdout;
               nx++;
            end
         end else begin
            en = 1'b1;
            #1;
            if (!tx_ready) begin
               gap++;
            end else begin
               ok = 1'b1;
               break;
            end
         end
         tick();
      end
      sready_drv = 1'b1;
   endtask

   task automatic rx_send(input logic [23:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         sdin_valid_drv = 1'b1;
         sdin_drv       = w[i];
         tick();
      end
   endtask

   logic [23:0] got;
   int          vc;
   int          nx;
   int          gap;
   bit          ok;

   initial begin
      rst            = 1'b1;
      en             = 1'b1;
      tx_word        = '0;
      tx_valid       = 1'b0;
      sready_drv     = 1'b1;
      sdin_drv       = 1'b0;
      sdin_valid_drv = 1'b0;
      lb             = 1'b0;

      // Reset state
      repeat (3) tick();
      check_eq("rst_tx_ready", tx_ready, 0);
      check_eq("rst_sready", sready, 0);
      check_eq("rst_sdout_valid", sdout_valid, 0);
      check_eq("rst_sdout", sdout, 0);
      check_eq("rst_rx_word", rx_word, 0);
      check_eq("rst_rx_valid", rx_valid, 0);
      check_eq("rst_rx_err", rx_err, 0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_tx_ready", tx_ready, 1);
      check_eq("post_rst_sready", sready, 1);

      // Enable low blocks acceptance
      en = 1'b0;
      #1;
      check_eq("en_low_tx_ready", tx_ready, 0);
      check_eq("en_low_sready", sready, 0);
      tx_valid = 1'b1;
      tx_word  = 24'h000123;
      repeat (3) tick();
      check_eq("en_low_no_tx", sdout_valid, 0);
      tx_valid = 1'b0;
      en       = 1'b1;
      tick();

      // TX 0x000001, far end always ready
      send_tx(24'h000001, 1'b0, 1'b0, got, vc, nx, gap, ok);
      check_eq("t1_done", ok, 1);
      check_eq("t1_word", got, 24'h000001);
      check_eq("t1_valid_cycles", vc, 24);
      check_eq("t1_xfers", nx, 24);
      check_eq("t1_gap", gap, GapExp);

      // TX 0xA5A5A5, far end ready every other cycle
      send_tx(24'hA5A5A5, 1'b1, 1'b0, got, vc, nx, gap, ok);
      check_eq("t2_done", ok, 1);
      check_eq("t2_word", got, 24'hA5A5A5);
      check_eq("t2_valid_cycles", vc, 48);
      check_eq("t2_xfers", nx, 24);
      check_eq("t2_gap", gap, GapExp);

      // Dropping enable mid-word does not disturb the word in flight
      send_tx(24'h0F0F0F, 1'b0, 1'b1, got, vc, nx, gap, ok);
      check_eq("t3_done", ok, 1);
      check_eq("t3_word", got, 24'h0F0F0F);
      check_eq("t3_valid_cycles", vc, 24);

      // RX full word
      rx_send(24'h7FFFFF, 24);
      sdin_valid_drv = 1'b0;
      check_eq("rx1_valid", rx_valid, 1);
      check_eq("rx1_word", rx_word, 24'h7FFFFF);
      check_eq("rx1_err", rx_err, 0);
      tick();
      check_eq("rx1_valid_pulse", rx_valid, 0);
      check_eq("rx1_no_err", rx_err, 0);

      // RX abort after 10 bits
      rx_send(24'h000ABC, 10);
      sdin_valid_drv = 1'b0;
      check_eq("rx2_err_early", rx_err, 0);
      tick();
      check_eq("rx2_err", rx_err, 1);
      check_eq("rx2_word_kept", rx_word, 24'h7FFFFF);
      check_eq("rx2_no_valid", rx_valid, 0);
      tick();
      check_eq("rx2_err_pulse", rx_err, 0);
      rx_send(24'h123456, 24);
      sdin_valid_drv = 1'b0;
      check_eq("rx3_valid", rx_valid, 1);
      check_eq("rx3_word", rx_word, 24'h123456);
      tick();

      // RX back-to-back with valid held
      rx_send(24'hABCDEF, 24);
      check_eq("rx4_valid", rx_valid, 1);
      check_eq("rx4_word", rx_word, 24'hABCDEF);
      rx_send(24'h13579B, 24);
      sdin_valid_drv = 1'b0;
      check_eq("rx5_valid", rx_valid, 1);
      check_eq("rx5_word", rx_word, 24'h13579B);
      tick();
      check_eq("rx5_no_err", rx_err, 0);

      // Reset in the middle of a TX word
      tx_valid = 1'b1;
      tx_word  = 24'h5A5A5A;
      tick();
      tx_valid = 1'b0;
      repeat (12) tick();
      check_eq("mid_rst_pre_valid", sdout_valid, 1);
      rst = 1'b1;
      tick();
      check_eq("mid_rst_valid", sdout_valid, 0);
      check_eq("mid_rst_tx_ready", tx_ready, 0);
      check_eq("mid_rst_rx_err", rx_err, 0);
      rst = 1'b0;
      send_tx(24'hFFFFFF, 1'b0, 1'b0, got, vc, nx, gap, ok);
      check_eq("t4_done", ok, 1);
      check_eq("t4_word", got, 24'hFFFFFF);
      check_eq("t4_valid_cycles", vc, 24);
      check_eq("t4_xfers", nx, 24);

      // Loopback of 100 sine samples
      lb = 1'b1;
      tick();
      for (int i = 0; i < 100; i++) begin
         real         r;
         int          s;
         int          k;
         logic [23:0] w;
         r = 8388607.0 * $sin(2.0 * 3.14159265358979 * i / 100.0);
         s = $rtoi(r);
         w = s[23:0];
         k = 0;
         while (!tx_ready && k < 200) begin
            tick();
            k++;
         end
         tx_valid = 1'b1;
         tx_word  = w;
         tick();
         tx_valid = 1'b0;
         k = 0;
         while (!rx_valid && k < 100) begin
            tick();
            k++;
         end
         check_eq("lb_valid", rx_valid, 1);
         check_eq("lb_word", rx_word, w);
      end
      repeat (3) tick();
      lb = 1'b0;
      check_eq("lb_err_count", lb_err, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
